// File: rtl/spawn_scheduler_if.sv
// Signal bundle between game logic, the spawn scheduler and the obstacle units.
// Optional SPAWN_SCHED_LIVES_EN adds the lives counter output.
interface spawn_scheduler_if #(
    parameter int N_OBJ = 10
);
    logic             start;
    logic             collision;
    logic [N_OBJ-1:0] obj_done;
    logic [N_OBJ-1:0] obj_active;
    logic [1:0]       level;
    logic             banner;
    logic             game_won;
    logic             restart_pulse;
    logic [9:0]       tick_count;
`ifdef SPAWN_SCHED_LIVES_EN
    logic [1:0]       lives;

    modport master (
        input  start, collision, obj_done,
        output obj_active, level, banner, game_won, restart_pulse, tick_count, lives
    );
    modport slave (
        output start, collision, obj_done,
        input  obj_active, level, banner, game_won, restart_pulse, tick_count, lives
    );
`else
    modport master (
        input  start, collision, obj_done,
        output obj_active, level, banner, game_won, restart_pulse, tick_count
    );
    modport slave (
        output start, collision, obj_done,
        input  obj_active, level, banner, game_won, restart_pulse, tick_count
    );
`endif
endinterface

// File: rtl/spawn_scheduler.sv
// Timed obstacle release / retire / level sequencing for the sprite datapath.
// Define SPAWN_SCHED_LIVES_EN to add a limited-lives counter (MAX_LIVES).
module spawn_scheduler #(
    parameter int N_OBJ         = 10,
    parameter int CLKS_PER_TICK = 50000000,
    parameter int INTRO_TICKS   = 1,
    parameter int SPAWN_GAP     = 2,
    parameter int MID_TICKS     = 3,
    parameter int N_LEVELS      = 2
`ifdef SPAWN_SCHED_LIVES_EN
    ,
    parameter int MAX_LIVES     = 3
`endif
) (
    input  logic              Clk,
    input  logic              Reset,
    spawn_scheduler_if.master bus
);
    localparam int PRE_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int IDX_W = $clog2(N_OBJ + 1);
    localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(CLKS_PER_TICK - 1);
    localparam logic [9:0]       TC_MAX     = 10'd1023;
    localparam logic [9:0]       INTRO_LAST = (INTRO_TICKS > 0) ? 10'(INTRO_TICKS - 1) : 10'd0;
    localparam logic [9:0]       GAP_LAST   = (SPAWN_GAP > 0) ? 10'(SPAWN_GAP - 1) : 10'd0;
    localparam logic [9:0]       MID_LAST   = (MID_TICKS > 0) ? 10'(MID_TICKS - 1) : 10'd0;
    localparam logic [1:0]       LAST_LEVEL = 2'(N_LEVELS - 1);
    localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(N_OBJ);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [N_OBJ-1:0] FIRST_BIT  = N_OBJ'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INTRO,
        S_SPAWN,
        S_DRAIN,
        S_MID,
        S_WON
    } state_t;

    // A single-obstacle level has nothing left to spawn after the entry spawn.
    localparam state_t ENTRY_STATE = (N_OBJ == 1) ? S_DRAIN : S_SPAWN;

    state_t           state_reg, state_next;
    logic [PRE_W-1:0] prescaler_reg, prescaler_next;
    logic [9:0]       tick_count_reg, tick_count_next;
    logic [IDX_W-1:0] spawn_idx_reg, spawn_idx_next;
    logic [1:0]       level_reg, level_next;
    logic [N_OBJ-1:0] active_reg, active_next;
    logic             banner_reg, banner_next;
    logic             won_reg, won_next;
    logic             restart_reg, restart_next;
`ifdef SPAWN_SCHED_LIVES_EN
    logic [1:0]       lives_reg, lives_next;
`endif

    logic             tick;
    logic             intro_done;
    logic             gap_done;
    logic             mid_done;
    logic             spawn_fire;
    logic             timer_clear;
    logic [N_OBJ-1:0] spawn_onehot;

    assign tick = (prescaler_reg == PRE_LAST);

    // "Reaches N ticks" fires on the edge where the count would become N.
    assign intro_done = (INTRO_TICKS == 0) || (tick && (tick_count_reg == INTRO_LAST));
    assign gap_done   = (SPAWN_GAP == 0)   || (tick && (tick_count_reg == GAP_LAST));
    assign mid_done   = (MID_TICKS == 0)   || (tick && (tick_count_reg == MID_LAST));

    genvar gi;
    generate
        for (gi = 0; gi < N_OBJ; gi++) begin : g_spawn_sel
            assign spawn_onehot[gi] = (spawn_idx_reg == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        spawn_idx_next = spawn_idx_reg;
        level_next     = level_reg;
        active_next    = active_reg;
        restart_next   = 1'b0;
        spawn_fire     = 1'b0;
`ifdef SPAWN_SCHED_LIVES_EN
        lives_next     = lives_reg;
`endif

        case (state_reg)
            S_IDLE, S_WON: begin
                active_next = '0;
                if (bus.start) begin
                    state_next = S_INTRO;
                    level_next = 2'd0;
`ifdef SPAWN_SCHED_LIVES_EN
                    lives_next = 2'(MAX_LIVES);
`endif
                end
            end
            S_INTRO, S_MID: begin
                if ((state_reg == S_INTRO) ? intro_done : mid_done) begin
                    state_next     = ENTRY_STATE;
                    active_next    = FIRST_BIT;
                    spawn_idx_next = IDX_ONE;
                end
            end
            S_SPAWN, S_DRAIN: begin
                if (bus.collision) begin
                    active_next    = '0;
                    spawn_idx_next = '0;
                    restart_next   = 1'b1;
                    state_next     = S_INTRO;
`ifdef SPAWN_SCHED_LIVES_EN
                    if (lives_reg <= 2'd1) begin
                        lives_next = 2'd0;
                        state_next = S_IDLE;
                    end else begin
                        lives_next = lives_reg - 2'd1;
                    end
`endif
                end else begin
                    // Retire first, then OR in the spawn so a same-cycle spawn wins.
                    active_next = active_reg & ~bus.obj_done;
                    if (state_reg == S_SPAWN) begin
                        if (gap_done) begin
                            spawn_fire     = 1'b1;
                            active_next    = active_next | spawn_onehot;
                            spawn_idx_next = spawn_idx_reg + IDX_ONE;
                            if (spawn_idx_next == IDX_END)
                                state_next = S_DRAIN;
                        end
                    end else if (active_reg == '0) begin
                        if (level_reg == LAST_LEVEL) begin
                            state_next = S_WON;
                        end else begin
                            state_next = S_MID;
                            level_next = level_reg + 2'd1;
                        end
                    end
                end
            end
            default: begin
                state_next  = S_IDLE;
                active_next = '0;
            end
        endcase

        // Each state (and each spawn step) times from zero.
        timer_clear = (state_next != state_reg) || spawn_fire;
        if (timer_clear || tick)
            prescaler_next = '0;
        else
            prescaler_next = prescaler_reg + PRE_W'(1);

        if (timer_clear)
            tick_count_next = 10'd0;
        else if (tick && (tick_count_reg != TC_MAX))
            tick_count_next = tick_count_reg + 10'd1;
        else
            tick_count_next = tick_count_reg;

        banner_next = (state_next != S_SPAWN) && (state_next != S_DRAIN);
        won_next    = (state_next == S_WON);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg      <= S_IDLE;
            prescaler_reg  <= '0;
            tick_count_reg <= 10'd0;
            spawn_idx_reg  <= '0;
            level_reg      <= 2'd0;
            active_reg     <= '0;
            banner_reg     <= 1'b1;
            won_reg        <= 1'b0;
            restart_reg    <= 1'b0;
`ifdef SPAWN_SCHED_LIVES_EN
            lives_reg      <= 2'(MAX_LIVES);
`endif
        end else begin
            state_reg      <= state_next;
            prescaler_reg  <= prescaler_next;
            tick_count_reg <= tick_count_next;
            spawn_idx_reg  <= spawn_idx_next;
            level_reg      <= level_next;
            active_reg     <= active_next;
            banner_reg     <= banner_next;
            won_reg        <= won_next;
            restart_reg    <= restart_next;
`ifdef SPAWN_SCHED_LIVES_EN
            lives_reg      <= lives_next;
`endif
        end
    end

    assign bus.obj_active    = active_reg;
    assign bus.level         = level_reg;
    assign bus.banner        = banner_reg;
    assign bus.game_won      = won_reg;
    assign bus.restart_pulse = restart_reg;
    assign bus.tick_count    = tick_count_reg;
`ifdef SPAWN_SCHED_LIVES_EN
    assign bus.lives         = lives_reg;
`endif

endmodule

// File: doc/spawn_scheduler.md
Name: spawn_scheduler

Overview:
Game-flow controller that sequences obstacle release for the sprite datapath. It produces per-obstacle enable bits on a timed schedule and retires obstacles when they leave the screen. It restarts the current level on player collision and advances through levels with banner intervals between them. It sits between the top-level game logic and the obstacle motion/draw units, replacing hand-enumerated per-block states with a parameterized scheduler.

Parameters:
N_OBJ, 10, number of obstacles per level (1..32)
CLKS_PER_TICK, 50000000, Clk cycles per game tick (1 s at 50 MHz)
INTRO_TICKS, 1, ticks of banner before first spawn of a level
SPAWN_GAP, 2, ticks between consecutive spawns
MID_TICKS, 3, ticks of inter-level banner
N_LEVELS, 2, number of levels (1..4)

Ports:
Clk  in  1  system clock
Reset  in  1  reset; asynchronous, active-high
start  in  1  start/restart game request, sampled on Clk
collision  in  1  player hit; level-sensitive, already synchronous to Clk
obj_done  in  N_OBJ  bit i high = obstacle i left screen
obj_active  out  N_OBJ  bit i high = obstacle i enabled for motion/draw
level  out  2  current level index, 0-based
banner  out  1  high while title/level banner is shown
game_won  out  1  high in WON state
restart_pulse  out  1  one-cycle pulse when a collision restarts the level
tick_count  out  10  ticks elapsed in current state, saturates at 1023

Behaviour:
- Reset (async): state=IDLE, prescaler=0, tick_count=0, spawn_idx=0, level=0, obj_active=0, banner=1, game_won=0, restart_pulse=0.
- Prescaler counts 0..CLKS_PER_TICK-1. The tick strobe is high for one cycle at terminal count; tick_count increments on the strobe.
- Every state transition clears the prescaler and tick_count in the same edge, so each state starts timing from 0.
- All outputs are registered. A condition true in cycle n produces the new state/outputs at edge n+1.
- States:
  - IDLE: banner=1, obj_active=0. start -> INTRO with level=0.
  - INTRO: banner=1. When tick_count reaches INTRO_TICKS -> SPAWN; on that edge obj_active[0]<=1 and spawn_idx<=1.
  - SPAWN: banner=0. Each time tick_count reaches SPAWN_GAP: set obj_active[spawn_idx], increment spawn_idx, clear tick_count and prescaler. When spawn_idx==N_OBJ -> DRAIN. With N_OBJ=1, go directly to DRAIN after the entry spawn.
  - DRAIN: no spawns. When obj_active==0 -> WON if level==N_LEVELS-1, else MID with level+1.
  - MID: banner=1. When tick_count reaches MID_TICKS -> SPAWN with the same entry action as INTRO.
  - WON: game_won=1, banner=1, obj_active=0. start -> INTRO with level=0.
- Retire: in SPAWN/DRAIN, obj_done[i]=1 clears obj_active[i]. obj_done on inactive bits is ignored.
- Same cycle spawn and done on bit i: the spawn wins and the bit ends set.
- Collision: in SPAWN or DRAIN, collision=1 has priority over every other event. It clears obj_active and spawn_idx, pulses restart_pulse for one cycle, and goes to INTRO keeping level. Collision is ignored in IDLE, INTRO, MID and WON.
- start is ignored outside IDLE and WON.
- Reset asserted mid-level aborts immediately to the reset values above.
- tick_count never wraps; it holds at 1023.

Optional Feature:
SPAWN_SCHED_LIVES_EN
- With the macro: adds parameter MAX_LIVES (default 3) and output lives [1:0].
  - lives loads MAX_LIVES on Reset and on start.
  - Each honoured collision decrements lives.
  - A collision with lives==1 sets lives=0 and goes to IDLE instead of INTRO; restart_pulse still fires.
- Without the macro: the lives port and logic are absent, and collisions always restart the level (unlimited retries).

Test Plan:
All scenarios use CLKS_PER_TICK=4, N_OBJ=3, INTRO_TICKS=1, SPAWN_GAP=2, MID_TICKS=3, N_LEVELS=2.
1. Reset, pulse start -> INTRO banner=1 for 4 clks; then obj_active=001, then 011 after 8 clks, then 111 after 8 more; state DRAIN; tick_count resets to 0 at each step.
2. In DRAIN, pulse obj_done=111 -> obj_active=000 next cycle; MID, level=1, banner=1 for 12 clks; then obj_active=001.
3. Level 1 drained -> game_won=1, obj_active=000; start -> INTRO, level=0, game_won=0.
4. Collision while obj_active=011 in level 1 -> restart_pulse high exactly 1 cycle, obj_active=000, INTRO, level stays 1; collision held during INTRO causes no second pulse.
5. Same cycle: spawn of bit 2 with obj_done=100, and separately collision with obj_done -> bit 2 set in the first case; collision wins (all clear) in the second.
6. Reset asserted mid-SPAWN between clock edges -> outputs return to reset values asynchronously. With SPAWN_SCHED_LIVES_EN: three collisions give lives 3->2->1->0 and state IDLE.
